sipo_deframer: RTL

Serial-to-parallel receive stage that consumes the LSB-first bit stream produced by the team's 4-bit parallel-in/serial-out shifter. It reassembles each group of WIDTH bits into a parallel word and presents it on a one-entry valid/ready output buffer. If the consumer stalls, completed words are dropped and a sticky overrun flag is raised. A frame-start input realigns word boundaries.

---
 rtl/sipo_pkg.sv | 19 +
 rtl/sipo_deframer_if.sv | 27 ++
 rtl/sipo_shift_core.sv | 64 ++++++
 rtl/sipo_deframer.sv | 90 +++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-to-parallel deframer: default word width,
// counter-width helper and the output-buffer state encoding.
package sipo_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Counter width for a WIDTH-bit word; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 32'sd1) ? $clog2(width) : 32'sd1;
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/sipo_deframer_if.sv
// Serial input and valid/ready parallel output of the deframer.
// slave is the deframer side, master the producer/consumer side.
interface sipo_deframer_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
);
    logic             sin;
    logic             sin_en;
    logic             frame_start;
    logic             dout_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             overrun;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output sin, sin_en, frame_start, dout_ready,
        input  dout, dout_valid, overrun, bit_cnt
    );

    modport slave (
        input  sin, sin_en, frame_start, dout_ready,
        output dout, dout_valid, overrun, bit_cnt
    );
endinterface

// File: rtl/sipo_shift_core.sv
// Bit collector: LSB-first shift register, bit counter and frame_start
// realignment. word/word_done are combinational on the current serial bit.
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             frame_start,
    output logic [WIDTH-1:0] word,
    output logic             word_done,
    output logic [CNT_W-1:0] bit_cnt
);

    // sr[0] is never stored: the last bit of a word comes straight from sin.
    logic [WIDTH-1:1] sr_r;
    logic [WIDTH-1:1] sr_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             last_bit_s;

    assign last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));
    assign word       = {sin, sr_r};
    // A realigning bit starts a new word, so it never completes the old one.
    assign word_done  = sin_en && last_bit_s && !frame_start;
    assign bit_cnt    = cnt_r;

    // Next shift-register contents and bit count.
    always_comb begin
        sr_nxt_s  = sr_r;
        cnt_nxt_s = cnt_r;
        if (frame_start) begin
            if (sin_en) begin
                sr_nxt_s  = (WIDTH-1)'(sin) << (WIDTH - 2);
                cnt_nxt_s = CNT_W'(1);
            end else begin
                sr_nxt_s  = {(WIDTH-1){1'b0}};
                cnt_nxt_s = {CNT_W{1'b0}};
            end
        end else if (sin_en) begin
            sr_nxt_s  = word[WIDTH-1:1];
            cnt_nxt_s = last_bit_s ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));
        end else begin
            sr_nxt_s  = sr_r;
            cnt_nxt_s = cnt_r;
        end
    end

    // Collector state registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            sr_r  <= {(WIDTH-1){1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            sr_r  <= sr_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

endmodule

// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: collector plus a one-entry output buffer
// that drops words on a stalled consumer and flags it with sticky overrun.
module sipo_deframer
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input logic             clk,
    input logic             clr,
    sipo_deframer_if.slave  bus
);

    logic [WIDTH-1:0] word_s;
    logic             word_done_s;
    logic [CNT_W-1:0] bit_cnt_s;

    buf_state_e       state_r;
    buf_state_e       state_nxt_s;
    logic [WIDTH-1:0] dout_r;
    logic [WIDTH-1:0] dout_nxt_s;
    logic             overrun_r;
    logic             overrun_nxt_s;

    sipo_shift_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk         (clk),
        .clr         (clr),
        .sin         (bus.sin),
        .sin_en      (bus.sin_en),
        .frame_start (bus.frame_start),
        .word        (word_s),
        .word_done   (word_done_s),
        .bit_cnt     (bit_cnt_s)
    );

    // Output-buffer next state, held word and overrun flag.
    always_comb begin
        state_nxt_s   = state_r;
        dout_nxt_s    = dout_r;
        overrun_nxt_s = overrun_r;
        case (state_r)
            ST_EMPTY: begin
                if (word_done_s) begin
                    dout_nxt_s  = word_s;
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (word_done_s) begin
                    if (bus.dout_ready) begin
                        dout_nxt_s = word_s;
                    end else begin
                        overrun_nxt_s = 1'b1;
                    end
                end else if (bus.dout_ready) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
            end
        endcase
    end

    // Output-buffer registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r   <= ST_EMPTY;
            dout_r    <= {WIDTH{1'b0}};
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            dout_r    <= dout_nxt_s;
            overrun_r <= overrun_nxt_s;
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = (state_r == ST_FULL);
    assign bus.overrun    = overrun_r;
    assign bus.bit_cnt    = bit_cnt_s;

endmodule
